// File: rtl/drive_arbiter.sv
// drive_arbiter: selects between the autonomous drive command and IR-remote manual
// driving, and sequences the result onto a registered motor command bus. A command
// must be held for a minimum dwell before another non-Stop command replaces it, and
// every left/right reversal or mode switch inserts a forced Stop dead-time.
//
// Ports:
//   clk           system clock
//   resetn        asynchronous active-low reset
//   auto_cmd      autonomous command (0 Stop,1 TurnLeft,2 Left,3 Straight,4 Right,5 TurnRight; 6/7 Stop)
//   auto_valid    auto_cmd is meaningful; low means the auto request is Stop
//   ir_command    decoded IR code
//   ir_data_ready one-cycle strobe qualifying ir_command
//   motor_cmd     registered command to the motor stage
//   manual_mode   1 = manual source selected
//   dead_active   1 while the forced Stop dead-time runs
//   cmd_changed   one-cycle pulse on the cycle motor_cmd takes a new value
module drive_arbiter #(
  parameter int unsigned MIN_DWELL      = 25_000_000,
  parameter int unsigned DEAD_TIME      = 10_000_000,
  parameter int unsigned MANUAL_TIMEOUT = 12_500_000,
  parameter logic [31:0] KEY_MANUAL     = 32'hfb046b86,
  parameter logic [31:0] KEY_AUTO       = 32'hfa056b86,
  parameter logic [31:0] KEY_FWD        = 32'hf7086b86,
  parameter logic [31:0] KEY_LEFT       = 32'hf6096b86,
  parameter logic [31:0] KEY_RIGHT      = 32'hf50a6b86,
  parameter logic [31:0] KEY_STOP       = 32'hf40b6b86
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  auto_cmd,
  input  logic        auto_valid,
  input  logic [31:0] ir_command,
  input  logic        ir_data_ready,
  output logic [2:0]  motor_cmd,
  output logic        manual_mode,
  output logic        dead_active,
  output logic        cmd_changed
);

  localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);
  localparam int unsigned DEAD_W  = $clog2(DEAD_TIME + 1);
  localparam int unsigned TMO_W   = $clog2(MANUAL_TIMEOUT + 1);

  localparam logic [DWELL_W-1:0] DWELL_SAT = DWELL_W'(MIN_DWELL);
  localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEAD_TIME - 1);
  localparam logic [TMO_W-1:0]   TMO_SAT   = TMO_W'(MANUAL_TIMEOUT);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DEAD = 1'b1;

  localparam logic [2:0] CMD_STOP       = 3'd0;
  localparam logic [2:0] CMD_TURN_LEFT  = 3'd1;
  localparam logic [2:0] CMD_LEFT       = 3'd2;
  localparam logic [2:0] CMD_STRAIGHT   = 3'd3;
  localparam logic [2:0] CMD_RIGHT      = 3'd4;
  localparam logic [2:0] CMD_TURN_RIGHT = 3'd5;

  logic [0:0]         state_q, state_d;
  logic [2:0]         motor_q, motor_d;
  logic               changed_q, changed_d;
  logic               mode_q, mode_d;
  logic [2:0]         man_cmd_q, man_cmd_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;

  logic       mode_switch;
  logic [2:0] req;
  logic       reversal;

  // Registered request sources feed the request, so IR keys reach the motor two edges later.
  always_comb begin
    req = CMD_STOP;
    if (mode_q) begin
      if (tmo_q != TMO_SAT) req = man_cmd_q;
    end else if (auto_valid && (auto_cmd <= CMD_TURN_RIGHT)) begin
      req = auto_cmd;
    end
  end

  // Left-family to right-family (or back) needs a dead-time to spare the gearbox.
  always_comb begin
    reversal = 1'b0;
    if (((motor_q == CMD_TURN_LEFT) || (motor_q == CMD_LEFT)) &&
        ((req == CMD_RIGHT) || (req == CMD_TURN_RIGHT)))
      reversal = 1'b1;
    if (((motor_q == CMD_RIGHT) || (motor_q == CMD_TURN_RIGHT)) &&
        ((req == CMD_TURN_LEFT) || (req == CMD_LEFT)))
      reversal = 1'b1;
  end

  assign mode_switch = ir_data_ready &&
                       (((ir_command == KEY_MANUAL) && !mode_q) ||
                        ((ir_command == KEY_AUTO) && mode_q));

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    motor_d   = motor_q;
    dwell_d   = dwell_q;
    dead_d    = dead_q;
    mode_d    = mode_q;
    man_cmd_d = man_cmd_q;
    tmo_d     = tmo_q;
    changed_d = 1'b0;

    // Manual command register and its inactivity timeout, updated in either mode.
    if (tmo_q != TMO_SAT) tmo_d = tmo_q + TMO_W'(1);
    if (ir_data_ready) begin
      case (ir_command)
        KEY_FWD:   begin man_cmd_d = CMD_STRAIGHT;   tmo_d = '0; end
        KEY_LEFT:  begin man_cmd_d = CMD_TURN_LEFT;  tmo_d = '0; end
        KEY_RIGHT: begin man_cmd_d = CMD_TURN_RIGHT; tmo_d = '0; end
        KEY_STOP:  begin man_cmd_d = CMD_STOP;       tmo_d = '0; end
        default:   ;
      endcase
    end

    if (mode_switch) begin
      // Mode switch overrides any request change and restarts the dead-time.
      mode_d  = !mode_q;
      state_d = ST_DEAD;
      motor_d = CMD_STOP;
      dead_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dwell_q != DWELL_SAT) dwell_d = dwell_q + DWELL_W'(1);
          if (req != motor_q) begin
            if (req == CMD_STOP) begin
              motor_d = CMD_STOP;
              dwell_d = '0;
            end else if ((motor_q == CMD_STOP) || (dwell_q == DWELL_SAT)) begin
              if (reversal) begin
                state_d = ST_DEAD;
                motor_d = CMD_STOP;
                dead_d  = '0;
              end else begin
                motor_d = req;
                dwell_d = '0;
              end
            end
          end
        end
        ST_DEAD: begin
          motor_d = CMD_STOP;
          if (dead_q == DEAD_LAST) begin
            // Nothing pending is kept; the request is re-sampled in RUN with dwell satisfied.
            state_d = ST_RUN;
            dwell_d = DWELL_SAT;
          end else begin
            dead_d = dead_q + DEAD_W'(1);
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    changed_d = (motor_d != motor_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_RUN;
      motor_q   <= CMD_STOP;
      changed_q <= 1'b0;
      mode_q    <= 1'b0;
      man_cmd_q <= CMD_STOP;
      tmo_q     <= TMO_SAT;
      dwell_q   <= DWELL_SAT;
      dead_q    <= '0;
    end else begin
      state_q   <= state_d;
      motor_q   <= motor_d;
      changed_q <= changed_d;
      mode_q    <= mode_d;
      man_cmd_q <= man_cmd_d;
      tmo_q     <= tmo_d;
      dwell_q   <= dwell_d;
      dead_q    <= dead_d;
    end
  end

  assign motor_cmd   = motor_q;
  assign manual_mode = mode_q;
  assign dead_active = (state_q == ST_DEAD);
  assign cmd_changed = changed_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed vector table, async-reset sequences and random stimulus
// checked against a behavioural model of drive_arbiter.
module tb_drive_arbiter;

  localparam int MD = 4;
  localparam int DT = 3;
  localparam int MT = 10;

  localparam logic [31:0] K_MAN   = 32'hfb046b86;
  localparam logic [31:0] K_AUTO  = 32'hfa056b86;
  localparam logic [31:0] K_FWD   = 32'hf7086b86;
  localparam logic [31:0] K_LEFT  = 32'hf6096b86;
  localparam logic [31:0] K_RIGHT = 32'hf50a6b86;
  localparam logic [31:0] K_STOP  = 32'hf40b6b86;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  auto_cmd;
  logic        auto_valid;
  logic [31:0] ir_command;
  logic        ir_data_ready;
  logic [2:0]  motor_cmd;
  logic        manual_mode;
  logic        dead_active;
  logic        cmd_changed;

  drive_arbiter #(
    .MIN_DWELL      (MD),
    .DEAD_TIME      (DT),
    .MANUAL_TIMEOUT (MT)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .auto_cmd      (auto_cmd),
    .auto_valid    (auto_valid),
    .ir_command    (ir_command),
    .ir_data_ready (ir_data_ready),
    .motor_cmd     (motor_cmd),
    .manual_mode   (manual_mode),
    .dead_active   (dead_active),
    .cmd_changed   (cmd_changed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Behavioural model: elapsed-time counters and a dead-time countdown.
  int m_cmd, m_man_cmd, m_since_key, m_since_chg, m_dead_left;
  bit m_manual, m_changed;

  task automatic model_reset();
    m_cmd = 0; m_man_cmd = 0; m_since_key = MT; m_since_chg = MD;
    m_dead_left = 0; m_manual = 0; m_changed = 0;
  endtask

  function automatic bit is_l(int c); return (c == 1) || (c == 2); endfunction
  function automatic bit is_r(int c); return (c == 4) || (c == 5); endfunction

  task automatic model_step(input int ac, input bit av, input logic [31:0] ir, input bit rdy);
    int req;
    int nxt;
    bit sw;
    if (m_manual) req = (m_since_key >= MT) ? 0 : m_man_cmd;
    else          req = (av && ac <= 5) ? ac : 0;
    sw  = rdy && ((ir == K_MAN && !m_manual) || (ir == K_AUTO && m_manual));
    nxt = m_cmd;
    if (sw) begin
      m_dead_left = DT; nxt = 0;
    end else if (m_dead_left > 0) begin
      m_dead_left--; nxt = 0;
      if (m_dead_left == 0) m_since_chg = MD;
    end else if (req != m_cmd && req == 0) begin
      nxt = 0; m_since_chg = 0;
    end else if (req != m_cmd && (m_cmd == 0 || m_since_chg >= MD)) begin
      if ((is_l(m_cmd) && is_r(req)) || (is_r(m_cmd) && is_l(req))) begin
        m_dead_left = DT; nxt = 0;
      end else begin
        nxt = req; m_since_chg = 0;
      end
    end else if (m_since_chg < 1000) begin
      m_since_chg++;
    end
    if (rdy && (ir == K_FWD || ir == K_LEFT || ir == K_RIGHT || ir == K_STOP)) begin
      m_man_cmd = (ir == K_FWD) ? 3 : (ir == K_LEFT) ? 1 : (ir == K_RIGHT) ? 5 : 0;
      m_since_key = 0;
    end else if (m_since_key < MT) begin
      m_since_key++;
    end
    if (sw) m_manual = !m_manual;
    m_changed = (nxt != m_cmd);
    m_cmd = nxt;
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input int ac, input bit av, input logic [31:0] ir, input bit rdy);
    auto_cmd = 3'(ac); auto_valid = av; ir_command = ir; ir_data_ready = rdy;
    model_step(ac, av, ir, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag, input int idx);
    check({tag, ".motor_cmd"},   idx, int'(motor_cmd),   m_cmd);
    check({tag, ".manual_mode"}, idx, int'(manual_mode), int'(m_manual));
    check({tag, ".dead_active"}, idx, int'(dead_active), int'(m_dead_left > 0));
    check({tag, ".cmd_changed"}, idx, int'(cmd_changed), int'(m_changed));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".motor_cmd"},   0, int'(motor_cmd),   0);
    check({tag, ".manual_mode"}, 0, int'(manual_mode), 0);
    check({tag, ".dead_active"}, 0, int'(dead_active), 0);
    check({tag, ".cmd_changed"}, 0, int'(cmd_changed), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    auto_cmd = '0; auto_valid = 1'b0; ir_command = '0; ir_data_ready = 1'b0;
    @(posedge clk); #1;
    check_zero("reset_hold");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [2:0]  ac;
    logic [31:0] ir;
    logic        rdy;
    logic [2:0]  em;
    logic        emm;
    logic        ed;
    logic        ec;
  } vec_t;

  function automatic vec_t mk(input int ac, input logic [31:0] ir, input bit rdy,
                              input int em, input bit emm, input bit ed, input bit ec);
    vec_t v;
    v.ac = 3'(ac); v.ir = ir; v.rdy = rdy; v.em = 3'(em); v.emm = emm; v.ed = ed; v.ec = ec;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int ac;
    bit av;
    logic [31:0] ir;
    bit rdy;

    // Directed table, av = 1 throughout; columns: auto, ir, rdy, motor, manual, dead, changed.
    tbl.push_back(mk(3, 0, 0, 3, 0, 0, 1));
    repeat (4) tbl.push_back(mk(4, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(2, 0, 0, 2, 0, 0, 1));
    repeat (4) tbl.push_back(mk(2, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(5, 0, 0, 0, 0, 1, 1));
    repeat (2) tbl.push_back(mk(5, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5, 0, 0, 5, 0, 0, 1));
    tbl.push_back(mk(3, K_MAN, 1, 0, 1, 1, 1));
    tbl.push_back(mk(3, K_FWD, 1, 0, 1, 1, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 3, 1, 0, 1));
    repeat (7) tbl.push_back(mk(3, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(3, K_LEFT, 1, 0, 1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(3, K_RIGHT, 1, 1, 1, 0, 0));
    repeat (3) tbl.push_back(mk(3, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(4, K_AUTO, 1, 0, 0, 1, 0));
    repeat (2) tbl.push_back(mk(4, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 4, 0, 0, 1));
    tbl.push_back(mk(4, K_AUTO, 1, 4, 0, 0, 0));

    do_reset();
    check_zero("reset_release");

    for (int i = 0; i < tbl.size(); i++) begin
      tick(int'(tbl[i].ac), 1'b1, tbl[i].ir, tbl[i].rdy);
      check("tbl.motor_cmd",   i, int'(motor_cmd),   int'(tbl[i].em));
      check("tbl.manual_mode", i, int'(manual_mode), int'(tbl[i].emm));
      check("tbl.dead_active", i, int'(dead_active), int'(tbl[i].ed));
      check("tbl.cmd_changed", i, int'(cmd_changed), int'(tbl[i].ec));
    end

    // Async reset mid-dwell: outputs clear without a clock edge.
    do_reset();
    tick(3, 1'b1, 32'h0, 1'b0);
    check_model("pre_rst_dwell", 0);
    #2 resetn = 1'b0;
    #1 check_zero("async_rst_dwell");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Async reset mid-DEAD after a switch to manual mode.
    tick(3, 1'b1, 32'h0, 1'b0);
    tick(3, 1'b1, K_MAN, 1'b1);
    tick(3, 1'b1, 32'h0, 1'b0);
    check_model("pre_rst_dead", 0);
    #2 resetn = 1'b0;
    #1 check_zero("async_rst_dead");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Random stimulus against the model.
    ac = 3; av = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 5) == 0) ac = int'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) av = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 6))
        0: ir = K_MAN;
        1: ir = K_AUTO;
        2: ir = K_FWD;
        3: ir = K_LEFT;
        4: ir = K_RIGHT;
        5: ir = K_STOP;
        default: ir = $urandom;
      endcase
      if (!rdy) ir = 32'h0;
      tick(ac, av, ir, rdy);
      check_model("rand", n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
